// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction-memory request/response handshake bundle
interface if_fetch_ctrl_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ready,
        input  im_rvalid,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ready,
        output im_rvalid,
        output im_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch controller; IF_PERF_EN enables fetch/stall counters
module if_fetch_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_in,
    output logic                  pc_stall,
    input  logic                  redirect,
    input  logic                  id_stall,
    if_fetch_ctrl_if.master       im,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [31:0]           inst_pc,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           stall_cnt
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        load_out;

    assign im.im_req   = !rst && (state_q == S_REQ);
    assign im.im_addr  = pc_in;
    assign pc_stall    = rst || !(redirect || (state_q == S_WAIT && im.im_rvalid));

    assign inst_valid  = inst_valid_q;
    assign inst_out    = inst_out_q;
    assign inst_pc     = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        load_out     = 1'b0;
        // An entry survives only while decode holds it off.
        inst_valid_d = inst_valid_q && id_stall;

        if (redirect) begin
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                S_WAIT:  state_d = im.im_rvalid ? S_REQ : S_DROP;
                S_REQ:   state_d = im.im_ready  ? S_DROP : S_REQ;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (im.im_ready) begin
                        state_d  = S_WAIT;
                        req_pc_d = pc_in;
                    end
                end
                S_WAIT: begin
                    if (im.im_rvalid) begin
                        if (!inst_valid_q || !id_stall) begin
                            load_out     = 1'b1;
                            inst_out_d   = im.im_rdata;
                            inst_pc_d    = req_pc_q;
                            inst_valid_d = 1'b1;
                            state_d      = S_REQ;
                        end else begin
                            skid_data_d  = im.im_rdata;
                            skid_pc_d    = req_pc_q;
                            skid_valid_d = 1'b1;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall && skid_valid_q) begin
                        load_out     = 1'b1;
                        inst_out_d   = skid_data_q;
                        inst_pc_d    = skid_pc_q;
                        inst_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                default: begin
                    if (im.im_rvalid) state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            req_pc_q     <= 32'd0;
            inst_out_q   <= NOP;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            skid_data_q  <= 32'd0;
            skid_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, load_out};
        stall_cnt_d = stall_cnt_q + {31'd0, pc_stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = load_out;
    assign fetch_cnt   = 32'd0;
    assign stall_cnt   = 32'd0;
`endif
endmodule
